// File: rtl/ddr_request_arbiter.sv
// Arbitrates VGA line fetches (high priority) and draw-engine pixel writes into one DDR command stream.
// Define ARB_PERF_EN to build the backpressure stall counter on stall_count.
module ddr_request_arbiter #(
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int BURST_LEN = 8,
   parameter int ROW_BITS  = 13,
   parameter int COL_BITS  = 10
) (
   input  logic                clk25,
   input  logic                rst,
   input  logic                init_done,
   input  logic                fetch_req,
   input  logic [8:0]          fetch_line,
   output logic                fetch_busy,
   output logic                fetch_overrun,
   input  logic                wr_valid,
   input  logic [9:0]          wr_x,
   input  logic [8:0]          wr_y,
   input  logic [15:0]         wr_data,
   output logic                wr_ready,
   output logic                ddr_cmd_valid,
   input  logic                ddr_cmd_ready,
   output logic                ddr_cmd_write,
   output logic [1:0]          ddr_ba,
   output logic [ROW_BITS-1:0] ddr_row,
   output logic [COL_BITS-1:0] ddr_col,
   output logic [15:0]         ddr_wdata,
   output logic [15:0]         stall_count
);
   localparam int              ADDR_W  = 19;
   localparam int              N_BURST = H_RES / BURST_LEN;
   localparam logic [9:0]      H_LIM   = 10'(H_RES);
   localparam logic [8:0]      V_LIM   = 9'(V_RES);
   localparam logic [6:0]      K_LAST  = 7'(N_BURST - 1);
   localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(BURST_LEN);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE} state_t;

   state_t              r_state;
   logic                r_pending;
   logic                r_busy;
   logic                r_overrun;
   logic [8:0]          r_line;
   logic [6:0]          r_k;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_valid;
   logic                r_write;
   logic [15:0]         r_wdata;
   logic                r_wr_ready;

   logic                w_line_ok;
   logic                w_wr_in_range;
   logic                w_start_fetch;
   logic                w_accept;
   logic [ADDR_W-1:0]   w_line_addr;
   logic [ADDR_W-1:0]   w_wr_addr;

   // y*640 built as y*512 + y*128
   assign w_line_addr   = ({10'd0, r_line} << 9) + ({10'd0, r_line} << 7);
   assign w_wr_addr     = ({10'd0, wr_y} << 9) + ({10'd0, wr_y} << 7) + {9'd0, wr_x};
   assign w_line_ok     = fetch_line < V_LIM;
   assign w_wr_in_range = (wr_x < H_LIM) && (wr_y < V_LIM);
   assign w_start_fetch = (r_state == S_IDLE) && init_done && r_pending;
   assign w_accept      = r_valid && ddr_cmd_ready;

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pending  <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
         r_line     <= '0;
         r_k        <= '0;
         r_addr     <= '0;
         r_valid    <= 1'b0;
         r_write    <= 1'b0;
         r_wdata    <= '0;
         r_wr_ready <= 1'b0;
      end else begin
         r_wr_ready <= 1'b0;

         // A repeat request may still retarget a fetch that has not been launched yet.
         if (fetch_req && w_line_ok) begin
            if (r_busy) begin
               r_overrun <= 1'b1;
               if (r_pending && !w_start_fetch)
                  r_line <= fetch_line;
            end else begin
               r_line    <= fetch_line;
               r_pending <= 1'b1;
               r_busy    <= 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_start_fetch) begin
                  r_pending <= 1'b0;
                  r_addr    <= w_line_addr;
                  r_write   <= 1'b0;
                  r_k       <= '0;
                  r_valid   <= 1'b1;
                  r_state   <= S_FETCH;
               end else if (wr_valid && !r_wr_ready) begin
                  // The ready pulse just issued still belongs to the previous write.
                  if (!w_wr_in_range) begin
                     r_wr_ready <= 1'b1;
                  end else if (init_done) begin
                     r_addr  <= w_wr_addr;
                     r_wdata <= wr_data;
                     r_write <= 1'b1;
                     r_valid <= 1'b1;
                     r_state <= S_WRITE;
                  end
               end
            end
            S_FETCH: begin
               if (w_accept) begin
                  if (r_k == K_LAST) begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_k     <= r_k + 7'd1;
                     r_addr  <= r_addr + A_STEP;
                     r_valid <= init_done;
                  end
               end else if (!r_valid && init_done) begin
                  r_valid <= 1'b1;
               end
            end
            S_WRITE: begin
               if (w_accept) begin
                  r_valid    <= 1'b0;
                  r_wr_ready <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign fetch_busy    = r_busy;
   assign fetch_overrun = r_overrun;
   assign wr_ready      = r_wr_ready;
   assign ddr_cmd_valid = r_valid;
   assign ddr_cmd_write = r_write;
   assign ddr_wdata     = r_wdata;
   assign ddr_col       = r_addr[COL_BITS-1:0];
   assign ddr_ba        = r_addr[COL_BITS+1:COL_BITS];
   assign ddr_row       = ROW_BITS'(r_addr[ADDR_W-1:COL_BITS+2]);

`ifdef ARB_PERF_EN
   logic [15:0] r_stall;

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst)
         r_stall <= '0;
      else if (r_valid && !ddr_cmd_ready && (r_stall != 16'hFFFF))
         r_stall <= r_stall + 16'd1;
   end

   assign stall_count = r_stall;
`else
   assign stall_count = 16'd0;
`endif

endmodule
